// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    // One memory access is always the four phases below, in order.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that was not
// granted last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Pick a port from the current requests and the previous winner.
    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else begin
            gnt_idx = req[1];
        end
    end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: serialises loader (port 0) and controller (port 1) accesses onto the
// shared memory port. Each access is IDLE -> SETUP -> STROBE -> DONE, with the
// strobe, write enable, address and data all driven from flops.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              write0,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_clock,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_to,
    input  logic [DATA_W-1:0] mem_from,
    output logic              busy,
    output logic              grant
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              wr_q, wr_d;
    logic              mem_clock_q, mem_clock_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_to_q, mem_to_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              gnt_valid_s;
    logic              gnt_idx_s;

    rr_arb2 u_rr_arb2 (
        .req        ({req1, req0}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid_s),
        .gnt_idx    (gnt_idx_s)
    );

    // Next-state and next-output logic for the access sequencer.
    // mem_addr/mem_to double as the latched request fields: they are loaded at
    // the grant edge and held untouched until the next grant.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        wr_d         = wr_q;
        mem_clock_d  = 1'b0;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_to_d     = mem_to_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid_s) begin
                    if (gnt_idx_s) begin
                        wr_d       = write1;
                        mem_addr_d = addr1;
                        mem_to_d   = wdata1;
                    end else begin
                        wr_d       = write0;
                        mem_addr_d = addr0;
                        mem_to_d   = wdata0;
                    end
                    // Write enable settles during SETUP, ahead of the strobe.
                    mem_write_d  = wr_d;
                    grant_d      = gnt_idx_s;
                    last_grant_d = gnt_idx_s;
                    state_d      = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                mem_clock_d = 1'b1;
                state_d     = STROBE;
            end
            STROBE: begin
                // Strobe and write enable drop together on entry to DONE, so
                // the enable never moves while the strobe is high.
                mem_clock_d = 1'b0;
                mem_write_d = 1'b0;
                if (grant_q) begin
                    ack1_d = 1'b1;
                end else begin
                    ack0_d = 1'b1;
                end
                // mem_from is valid while the strobe is high; capture it here
                // so rdata is already stable while ack is visible.
                if (!wr_q) begin
                    if (grant_q) begin
                        rdata1_d = mem_from;
                    end else begin
                        rdata0_d = mem_from;
                    end
                end else begin
                    rdata0_d = rdata0_q;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any access immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            wr_q         <= 1'b0;
            mem_clock_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_to_q     <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            wr_q         <= wr_d;
            mem_clock_q  <= mem_clock_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_to_q     <= mem_to_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_clock = mem_clock_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_to    = mem_to_q;
    assign busy      = busy_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: constant vector table, hand-written reset
// and contention sequences, and randomized traffic against a transaction-level
// reference model (reference memory plus arbitration fairness bounds).
module tb_mem_arb;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       write0 = 1'b0, write1 = 1'b0;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic       mem_clock, mem_write;
    logic [7:0] mem_addr, mem_to, mem_from;
    logic       busy, grant;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] last_rd [2];
    int         ack_cnt [2];
    int         strobes = 0;
    logic       prev_we = 1'b0;
    int         order_q [$];

    typedef struct {
        logic       port;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_r0;
        logic [7:0] exp_r1;
    } vec_t;

    mem_arb dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .write0    (write0),
        .write1    (write1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_clock (mem_clock),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_to    (mem_to),
        .mem_from  (mem_from),
        .busy      (busy),
        .grant     (grant)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] b;
        b = i[7:0];
        return b ^ 8'h5A;
    endfunction

    // Memory model: fills itself, then writes on each rising strobe.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        forever begin
            @(posedge mem_clock);
            if (mem_write) mem[mem_addr] = mem_to;
        end
    end
    assign mem_from = mem[mem_addr];

    always @(posedge mem_clock) strobes++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d, required <= %0d", name, act, lim);
        end
    endtask

    // Ack counting and write-enable stability across the strobe high phase.
    always @(negedge clock) begin
        if (ack0) ack_cnt[0]++;
        if (ack1) ack_cnt[1]++;
        if (mem_clock) chk("we_stable_in_strobe", mem_write, prev_we);
        prev_we = mem_write;
    end

    function automatic logic ack_of(input int p);
        return (p == 0) ? ack0 : ack1;
    endfunction

    function automatic logic [7:0] rdata_of(input int p);
        return (p == 0) ? rdata0 : rdata1;
    endfunction

    task automatic drive(input int p, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0 = r; write0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; write1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // One requester transaction; entered and left one time unit after a rising edge.
    task automatic xact(input int p, input logic w, input logic [7:0] a, input logic [7:0] d, output int lat);
        int other0;
        bit got;
        drive(p, 1'b1, w, a, d);
        other0 = ack_cnt[1-p];
        lat = 0;
        got = 1'b0;
        while (!got && lat < 50) begin
            @(posedge clock); #1;
            lat++;
            got = ack_of(p);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout port%0d: no ack after %0d cycles, required within 7", p, lat);
            drive(p, 1'b0, w, a, d);
        end else begin
            chk("grant_at_ack", grant, p);
            chk("busy_at_ack", busy, 1);
            chk_le("ack_latency_bound", lat, 7);
            chk_le("other_acks_while_waiting", ack_cnt[1-p] - other0, 1);
            order_q.push_back(p);
            if (w) ref_mem[a] = d;
            else   last_rd[p] = ref_mem[a];
            @(posedge clock); #1;
            drive(p, 1'b0, w, a, d);
            chk("ack_single_cycle", ack_of(p), 0);
            chk("rdata_vs_model", rdata_of(p), last_rd[p]);
        end
    endtask

    task automatic run_port(input int p, input int n, input int maxgap);
        int lat;
        int g;
        logic w;
        logic [7:0] a, d;
        for (int k = 0; k < n; k++) begin
            g = $urandom_range(maxgap, 0);
            repeat (g) begin @(posedge clock); #1; end
            w = 1'($urandom_range(1, 0));
            a = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom_range(15, 0));
            d = 8'($urandom);
            xact(p, w, a, d, lat);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        int lat;
        int s0;
        s0 = strobes;
        xact(int'(v.port), v.wr, v.addr, v.wdata, lat);
        chk("vec_latency", lat, 3);
        chk("vec_one_strobe", strobes - s0, 1);
        chk("vec_rdata0", rdata0, v.exp_r0);
        chk("vec_rdata1", rdata1, v.exp_r1);
        if (v.wr) chk("vec_mem_written", mem[v.addr], v.wdata);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ack0"}, ack0, 0);
        chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_rdata0"}, rdata0, 0);
        chk({tag, "_rdata1"}, rdata1, 0);
        chk({tag, "_mem_clock"}, mem_clock, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_to"}, mem_to, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant"}, grant, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [11];
        vec_t lv;
        int   a1, lat0, lat1, mism;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        ack_cnt[0] = 0; ack_cnt[1] = 0;

        vecs[0]  = '{1'b0, 1'b1, 8'h10, 8'h3C, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h3C, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 8'hFF, 8'h77, 8'h3C, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h3C, 8'h77};
        vecs[4]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h77, 8'h77};
        vecs[5]  = '{1'b1, 1'b1, 8'h10, 8'hC3, 8'h77, 8'h77};
        vecs[6]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h77, 8'hC3};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 8'hC3};
        vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h5A, 8'hC3};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hC3};
        vecs[10] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h5B};

        // Power-on reset values.
        #12;
        check_reset_vals("por");
        @(posedge clock); #1;
        reset = 1'b0;

        // Single-port accesses with constant expectations.
        for (int i = 0; i < 11; i++) apply_vec(vecs[i]);

        // Loader stream: port 0 writes 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            lv = '{1'b0, 1'b1, 8'(i), 8'hC0 + 8'(i), 8'h00, 8'h5B};
            apply_vec(lv);
        end
        for (int i = 0; i < 16; i++) chk("loader_image", mem[i], 8'hC0 + 8'(i));

        lv = '{1'b1, 1'b1, 8'h20, 8'h11, 8'h00, 8'h5B};
        apply_vec(lv);

        // Reset during SETUP of a port 1 write: the write must not land.
        a1 = ack_cnt[1];
        drive(1, 1'b1, 1'b1, 8'h20, 8'hA5);
        @(posedge clock); #2;
        chk("setup_busy", busy, 1);
        chk("setup_no_strobe", mem_clock, 0);
        reset = 1'b1;
        drive(1, 1'b0, 1'b1, 8'h20, 8'hA5);
        #1;
        check_reset_vals("rst_setup");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk("setup_rst_mem_unchanged", mem[8'h20], 8'h11);
        chk("setup_rst_no_ack1", ack_cnt[1] - a1, 0);

        // Reset during STROBE: the write is already committed, no ack.
        a1 = ack_cnt[1];
        drive(1, 1'b1, 1'b1, 8'h20, 8'hA5);
        @(posedge clock);
        @(posedge clock); #2;
        chk("strobe_high", mem_clock, 1);
        reset = 1'b1;
        drive(1, 1'b0, 1'b1, 8'h20, 8'hA5);
        #1;
        check_reset_vals("rst_strobe");
        ref_mem[8'h20] = 8'hA5;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk("strobe_rst_mem_committed", mem[8'h20], 8'hA5);
        chk("strobe_rst_no_ack1", ack_cnt[1] - a1, 0);

        // Simultaneous reads straight after reset: port 0 first, port 1 four cycles later.
        order_q.delete();
        fork
            xact(0, 1'b0, 8'h01, 8'h00, lat0);
            xact(1, 1'b0, 8'h02, 8'h00, lat1);
        join
        chk("simul_lat0", lat0, 3);
        chk("simul_lat1", lat1, 7);
        chk("simul_rdata0", rdata0, 8'hC1);
        chk("simul_rdata1", rdata1, 8'hC2);
        chk("simul_first_port", (order_q.size() > 0) ? order_q[0] : -1, 0);

        // Sustained contention: strictly alternating grants, four each.
        order_q.delete();
        fork
            run_port(0, 4, 0);
            run_port(1, 4, 0);
        join
        chk("contend_count", order_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("contend_order", (i < order_q.size()) ? order_q[i] : -1, i % 2);
        end

        // Randomized traffic with idle gaps.
        fork
            run_port(0, 40, 3);
            run_port(1, 40, 3);
        join

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("final_mem_image_mismatches", mism, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
